// File: rtl/dcache_write_buffer.sv
// Posted single-line write buffer: captures a dcache write-back burst at one beat per cycle, acks it at once,
// then drains the line to memory on its own and flags read misses that hit the held line.
module dcache_write_buffer #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_wvalid,
  output logic              c_wready,
  input  logic [ADDR_W-1:0] c_waddr,
  input  logic [31:0]       c_wdata,
  input  logic [3:0]        c_wstrb,
  input  logic              c_wlast,
  output logic              c_bvalid,
  input  logic              c_bready,
  input  logic [ADDR_W-1:0] chk_addr,
  output logic              rd_conflict,
  output logic              m_wvalid,
  input  logic              m_wready,
  output logic [ADDR_W-1:0] m_waddr,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wlast,
  output logic [2:0]        m_wsize,
  output logic [7:0]        m_wlen,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic              empty
);
  localparam int IW  = $clog2(LINE_WORDS);
  localparam int CW  = IW + 1;
  localparam int OFF = IW + 2;
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF;
  localparam logic [CW-1:0]     FULL_CNT  = CW'(LINE_WORDS);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, BRESP} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     r_rd_ptr;
  logic [ADDR_W-1:0] r_base;
  logic              r_c_bvalid;
  logic [31:0]       r_data [LINE_WORDS];
  logic [3:0]        r_strb [LINE_WORDS];

  logic          w_wr_ok;
  logic          w_accept;
  logic          w_fill_end;
  logic          w_drain;
  logic          w_last;
  logic [CW-1:0] w_cnt_inc;
  logic [CW-1:0] w_cnt_m1;

  assign w_wr_ok    = (r_state == FILL) || ((r_state == IDLE) && !r_c_bvalid);
  // Handshake stays dead while reset is held so no beat is half-captured.
  assign c_wready   = !rst && w_wr_ok;
  assign w_accept   = c_wvalid && c_wready;
  assign w_cnt_inc  = r_cnt + CW'(1);
  assign w_cnt_m1   = r_cnt - CW'(1);
  assign w_fill_end = w_accept && (c_wlast || (w_cnt_inc == FULL_CNT));
  assign w_drain    = (r_state == DRAIN);
  assign w_last     = (r_rd_ptr == w_cnt_m1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rd_ptr   <= '0;
      r_base     <= '0;
      r_c_bvalid <= 1'b0;
    end else begin
      if (w_fill_end) begin
        r_c_bvalid <= 1'b1;
      end else if (r_c_bvalid && c_bready) begin
        r_c_bvalid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_base  <= c_waddr & LINE_MASK;
            r_cnt   <= w_cnt_inc;
            r_state <= w_fill_end ? DRAIN : FILL;
          end
        end
        FILL: begin
          if (w_accept) begin
            r_cnt <= w_cnt_inc;
            if (w_fill_end) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (m_wready) begin
            if (w_last) begin
              r_rd_ptr <= '0;
              r_state  <= BRESP;
            end else begin
              r_rd_ptr <= r_rd_ptr + CW'(1);
            end
          end
        end
        BRESP: begin
          if (m_bvalid) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Line storage needs no reset: it is only read in DRAIN, after being written.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_data[r_cnt[IW-1:0]] <= c_wdata;
      r_strb[r_cnt[IW-1:0]] <= c_wstrb;
    end
  end

  assign c_bvalid    = r_c_bvalid;
  assign m_wvalid    = w_drain;
  assign m_waddr     = r_base;
  assign m_wdata     = w_drain ? r_data[r_rd_ptr[IW-1:0]] : 32'd0;
  assign m_wstrb     = w_drain ? r_strb[r_rd_ptr[IW-1:0]] : 4'd0;
  assign m_wlast     = w_drain && w_last;
  assign m_wsize     = 3'd2;
  assign m_wlen      = (r_cnt == '0) ? 8'd0 : 8'(w_cnt_m1);
  assign m_bready    = (r_state == BRESP);
  assign empty       = (r_state == IDLE);
  assign rd_conflict = !empty && ((chk_addr & LINE_MASK) == r_base);

endmodule

// File: doc/dcache_write_buffer.md
# dcache_write_buffer

Single-line posted write buffer between the data cache's dirty-line write-back port and the data-side write channel of the memory subsystem (the `d_w*` / `d_b*` port group). It captures a whole write-back burst from the cache at one beat per cycle and acknowledges it immediately. It then drains the line to memory as a burst on its own. While a line is held, it flags cache read misses whose line address matches the buffered line, so stale data is never refilled.

## Interface
- `LINE_WORDS`, 4: words per cache line; power of two, 2..16.
- `ADDR_W`, 32: address width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `c_wvalid`  in  1  cache write beat valid.
- `c_wready`  out  1  buffer can accept a beat.
- `c_waddr`  in  ADDR_W  line base address; sampled on the first beat only.
- `c_wdata`  in  32  beat data.
- `c_wstrb`  in  4  beat byte mask.
- `c_wlast`  in  1  last beat of the cache burst.
- `c_bvalid`  out  1  posted write acknowledge to the cache.
- `c_bready`  in  1  cache accepts the acknowledge.
- `chk_addr`  in  ADDR_W  cache read-miss address to check.
- `rd_conflict`  out  1  buffered line matches `chk_addr`.
- `m_wvalid`  out  1  memory write beat valid (to `d_wvalid`).
- `m_wready`  in  1  memory accepts a beat (from `d_wready`).
- `m_waddr`  out  ADDR_W  line base address, constant for the whole burst.
- `m_wdata`  out  32  beat data.
- `m_wstrb`  out  4  beat mask.
- `m_wlast`  out  1  last drain beat.
- `m_wsize`  out  3  constant 3'd2 (4-byte beats).
- `m_wlen`  out  8  number of captured beats minus 1.
- `m_bvalid`  in  1  write response valid from memory.
- `m_bready`  out  1  response accept.
- `empty`  out  1  no line held and no drain in progress.

## Operation
- Storage: `LINE_WORDS` × (32 data + 4 strb) registers, a base-address register, and a beat count `cnt` of $clog2(LINE_WORDS)+1 bits.
- The FSM has four states: IDLE, FILL, DRAIN and BRESP.
  - IDLE: `c_wready` = !`c_bvalid`. On a first beat (`c_wvalid`&&`c_wready`), latch `c_waddr` with the low $clog2(LINE_WORDS)+2 bits zeroed, write word 0, set `cnt`=1, and go to FILL. If that beat also has `c_wlast`, go directly to DRAIN.
  - FILL: `c_wready`=1. Each accepted beat writes word `cnt` and increments `cnt`. The burst ends on a beat carrying `c_wlast`, or on the beat that brings `cnt` to `LINE_WORDS`, whichever comes first; go to DRAIN. Beats beyond `LINE_WORDS` are never accepted.
  - DRAIN: `m_wvalid`=1. `m_wdata`/`m_wstrb` come from word `rd_ptr`, starting at 0. `m_wlast` = (`rd_ptr`==`cnt`-1). `rd_ptr` advances on `m_wvalid`&&`m_wready`. After the beat with `m_wlast`, go to BRESP.
  - BRESP: `m_bready`=1. On `m_bvalid`, clear `cnt` and go to IDLE.
- `c_bvalid` is set on the clock edge that accepts the burst-ending beat, and cleared on `c_bvalid`&&`c_bready`. It is independent of drain progress (posted write).
- `c_wready` is 0 in DRAIN and BRESP. A new line is accepted only from IDLE with `c_bvalid` clear.
- `rd_conflict` = (state≠IDLE) && (`chk_addr` line bits == stored base line bits). It is combinational and covers FILL as well.
- `empty` = (state==IDLE).
- `m_wlen` = `cnt`-1, zero-extended. It is stable throughout DRAIN and BRESP.

## Timing
- Reset (asynchronous): state=IDLE, `cnt`=0, `rd_ptr`=0. All outputs are 0 except `empty`=1 and `m_wsize`=2. Reset mid-burst discards the line with no response on either side.
- Fill: one beat per cycle. A full 4-word line takes 4 cycles.
- `c_bvalid` is first high in the cycle after the last fill beat.
- `m_wvalid` is first high in the cycle after the last fill beat; fill-to-drain latency is 1 cycle.
- The `m_w*` outputs are registered or derived from state plus `rd_ptr` only. While `m_wvalid`=1 they must not change until the beat is accepted. They never depend combinationally on `m_wready`.
- Simultaneous `m_bvalid` in BRESP with a pending `c_bvalid`: go to IDLE, but `c_wready` stays 0 until `c_bready`.
- `m_bvalid` outside BRESP is ignored (`m_bready`=0).

## Test plan
- Full line: 4 beats at `c_waddr`=0x0000_1234, data 0xA0..0xA3, `c_wlast` on beat 4, `m_wready`=1.
  - Required: `c_bvalid` high the next cycle; 4 drain beats with `m_waddr`=0x0000_1230, `m_wlen`=3 and `m_wlast` on 0xA3; `empty` returns 1 one cycle after `m_bvalid`.
- Short burst: 2 beats with `c_wlast` on beat 2.
  - Required: `m_wlen`=1, and exactly 2 drain beats are issued.
- Backpressure: `m_wready` toggles 1,0,0,1,...
  - Required: each beat is held stable while stalled, and data order is preserved.
- Conflict: line held at 0x100. `chk_addr`=0x10C gives `rd_conflict`=1. `chk_addr`=0x110 gives 0. After `m_bvalid`, 0x10C gives 0.
- Back-to-back lines: a second burst presented during DRAIN.
  - Required: `c_wready`=0 until the first line reaches IDLE and `c_bready` has been seen; then the second line is captured intact.
- Reset mid-DRAIN after 2 beats.
  - Required: all outputs immediately take reset values, `empty`=1, and the next burst is handled normally.
